// File: rtl/sect_pt_mul_arb.sv
// -----------------------------------------------------------------------------
// sect_pt_mul_arb
//
// Round-robin arbiter that shares one sect_pt_mul point-multiplier core among
// NUM_REQ requesters. A winner is picked only in IDLE. Its scalar is handed to
// the core with a one-cycle core_start, the core result is captured on
// core_done, and the requester gets a one-cycle one-hot ack with
// rsp_x/rsp_y/rsp_err valid in that cycle.
//
// Optional feature (compile-time macro SECT_ARB_TIMEOUT_EN):
//   A BUSY watchdog aborts a job after TIMEOUT_CYCLES BUSY cycles. It pulses
//   core_clr, returns a zero point and sets rsp_err=1. Without the macro there
//   is no counter, rsp_err is tied to 0, and BUSY waits for core_done forever.
//
// Ports:
//   clk, rst_n  : system clock (rising edge) and async active-low reset
//   clr         : synchronous clear (back to IDLE, aborts the core)
//   req         : [NUM_REQ] level request lines, held until ack
//   req_d       : [NUM_REQ*M] scalars, slice i = req_d[i*M +: M]
//   ack         : [NUM_REQ] one-hot completion pulse
//   rsp_x/rsp_y : [M] result point, held until the next capture
//   rsp_err     : timeout flag, valid with ack
//   busy        : high whenever the FSM is not IDLE
//   core_start  : one-cycle start to the core
//   core_d      : [M] scalar to the core, stable from START through RESP
//   core_clr    : core abort (clr, or watchdog expiry)
//   core_done, core_x, core_y : core completion and result point
// -----------------------------------------------------------------------------
module sect_pt_mul_arb #(
  parameter int M              = 163,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*M-1:0] req_d,
  output logic [NUM_REQ-1:0]   ack,
  output logic [M-1:0]         rsp_x,
  output logic [M-1:0]         rsp_y,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 core_start,
  output logic [M-1:0]         core_d,
  output logic                 core_clr,
  input  logic                 core_done,
  input  logic [M-1:0]         core_x,
  input  logic [M-1:0]         core_y
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [NUM_REQ-1:0]   ack_r;
  logic                 core_start_r;
  logic                 busy_r;
  logic [M-1:0]         rsp_x_r;
  logic [M-1:0]         rsp_y_r;
  logic [M-1:0]         core_d_r;
  logic [IDW-1:0]       gnt_id_r;
  logic [IDW-1:0]       last_gnt_r;
  logic [NUM_REQ-1:0]   req_eff_s;
  logic [IDW-1:0]       cand_s;
  logic [IDW-1:0]       win_s;
  logic                 found_s;
  logic [M-1:0]         win_d_s;
  logic                 tmo_hit_s;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = (idx == IDW'(i));
    end
    return v;
  endfunction

  // The requester being acked this cycle still shows req high (it can only
  // drop it after seeing ack), so it is masked to avoid serving it twice.
  assign req_eff_s = req & ~ack_r;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IDW'((int'(last_gnt_r) + k) % NUM_REQ);
      if (!found_s && req_eff_s[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        win_s   = win_s;
      end
    end
  end

  assign win_d_s = req_d[int'(win_s)*M +: M];

  // FSM next-state logic; clr overrides every state.
  always_comb begin
    state_nx_s = state_r;
    if (clr) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_nx_s = START;
          end else begin
            state_nx_s = IDLE;
          end
        end
        START: state_nx_s = BUSY;
        BUSY: begin
          if (core_done || tmo_hit_s) begin
            state_nx_s = RESP;
          end else begin
            state_nx_s = BUSY;
          end
        end
        RESP:    state_nx_s = IDLE;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Grant latch, core handshake, result capture and ack generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r        <= '0;
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
      rsp_x_r      <= '0;
      rsp_y_r      <= '0;
      core_d_r     <= '0;
      gnt_id_r     <= '0;
      last_gnt_r   <= LAST_RST;
    end else if (clr) begin
      // Arbitration history and the last response survive a clear.
      ack_r        <= '0;
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      ack_r        <= '0;
      core_start_r <= 1'b0;
      busy_r       <= (state_nx_s != IDLE);
      case (state_r)
        IDLE: begin
          if (found_s) begin
            gnt_id_r     <= win_s;
            core_d_r     <= win_d_s;
            core_start_r <= 1'b1;
          end else begin
            gnt_id_r     <= gnt_id_r;
          end
        end
        BUSY: begin
          if (core_done) begin
            rsp_x_r <= core_x;
            rsp_y_r <= core_y;
          end else if (tmo_hit_s) begin
            rsp_x_r <= '0;
            rsp_y_r <= '0;
          end else begin
            rsp_x_r <= rsp_x_r;
          end
        end
        RESP: begin
          ack_r      <= onehot(gnt_id_r);
          last_gnt_r <= gnt_id_r;
        end
        default: begin
          ack_r <= '0;
        end
      endcase
    end
  end

`ifdef SECT_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_r;
  logic            tmo_clr_r;
  logic            rsp_err_r;

  // Expires in the TIMEOUT_CYCLES-th BUSY cycle; core_done in that same cycle wins.
  assign tmo_hit_s = (state_r == BUSY) && !core_done &&
                     (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter, error flag and the one-cycle core abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_r  <= '0;
      tmo_clr_r <= 1'b0;
      rsp_err_r <= 1'b0;
    end else if (clr) begin
      wd_cnt_r  <= '0;
      tmo_clr_r <= 1'b0;
    end else begin
      tmo_clr_r <= 1'b0;
      case (state_r)
        START: wd_cnt_r <= '0;
        BUSY: begin
          if (core_done) begin
            rsp_err_r <= 1'b0;
          end else if (tmo_hit_s) begin
            rsp_err_r <= 1'b1;
            tmo_clr_r <= 1'b1;
          end else begin
            wd_cnt_r  <= wd_cnt_r + WD_W'(1);
          end
        end
        default: wd_cnt_r <= wd_cnt_r;
      endcase
    end
  end

  assign core_clr = rst_n & (clr | tmo_clr_r);
  assign rsp_err  = rsp_err_r;
`else
  assign tmo_hit_s = 1'b0;
  assign core_clr  = rst_n & clr;
  assign rsp_err   = 1'b0;
`endif

  // A clear suppresses an ack already in flight in the same cycle.
  assign ack        = clr ? '0 : ack_r;
  assign rsp_x      = rsp_x_r;
  assign rsp_y      = rsp_y_r;
  assign busy       = busy_r;
  assign core_start = core_start_r;
  assign core_d     = core_d_r;

endmodule

// File: tb/tb_sect_pt_mul_arb.sv
// -----------------------------------------------------------------------------
// tb_sect_pt_mul_arb
//
// Directed testbench for sect_pt_mul_arb (M=163, NUM_REQ=2, TIMEOUT_CYCLES=16).
// A behavioural core stands in for sect_pt_mul. For scalar 1 it returns the
// sect163k1 generator G. For any other scalar d it returns x = d << 1, y = ~d,
// after a fixed delay. Inputs change #1 after a rising edge. Outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_sect_pt_mul_arb;

  localparam int M  = 163;
  localparam int NR = 2;
  localparam logic [M-1:0] GX = 163'h2fe13c0537bbc11acaa07d793de4e6d5e5c94eee8;
  localparam logic [M-1:0] GY = 163'h289070fb05d38ff58321f2e800536d538ccdaa3d9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*M-1:0] req_d = '0;
  logic [NR-1:0]   ack;
  logic [M-1:0]    rsp_x;
  logic [M-1:0]    rsp_y;
  logic            rsp_err;
  logic            busy;
  logic            core_start;
  logic [M-1:0]    core_d;
  logic            core_clr;
  logic            core_done = 1'b0;
  logic [M-1:0]    core_x = '0;
  logic [M-1:0]    core_y = '0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0;
  int n_clr = 0;
  int done_cyc = 0;
  logic hang = 1'b0;
  logic active = 1'b0;
  int cnt = 0;

  logic [NR-1:0] a;
  int at;
  int t0;
  int s0;
  int c0;
  int seen;

  sect_pt_mul_arb #(
    .M(M), .NUM_REQ(NR), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .req_d(req_d),
    .ack(ack), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
    .core_start(core_start), .core_d(core_d), .core_clr(core_clr),
    .core_done(core_done), .core_x(core_x), .core_y(core_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [M-1:0] model_x(input logic [M-1:0] d);
    return (d == M'(1)) ? GX : {d[M-2:0], 1'b0};
  endfunction

  function automatic logic [M-1:0] model_y(input logic [M-1:0] d);
    return (d == M'(1)) ? GY : ~d;
  endfunction

  // Behavioural core: done three falling edges after seeing core_start.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (!rst_n || core_clr) begin
      active = 1'b0;
    end else if (core_start && !hang) begin
      active = 1'b1;
      cnt = 2;
    end else if (active) begin
      if (cnt == 0) begin
        core_done = 1'b1;
        core_x = model_x(core_d);
        core_y = model_y(core_d);
        active = 1'b0;
        done_cyc = cyc;
      end else begin
        cnt = cnt - 1;
      end
    end
  end

  // Event counters for start / abort pulses.
  always @(negedge clk) begin
    if (core_start) n_start = n_start + 1;
    if (core_clr) n_clr = n_clr + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget, output logic [NR-1:0] av, output int atc);
    av = '0;
    atc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack !== '0) begin
        av = ack;
        atc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    req = 2'b11;
    req_d[0 +: M] = 163'h5;
    req_d[M +: M] = 163'h9;
    repeat (3) @(negedge clk);
    n_vec++; if (ack !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b want 00", ack); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (core_start !== 1'b0) begin n_err++; $display("FAIL reset_core_start: got %b want 0", core_start); end
    n_vec++; if (core_clr !== 1'b0) begin n_err++; $display("FAIL reset_core_clr: got %b want 0", core_clr); end
    n_vec++; if (rsp_x !== '0) begin n_err++; $display("FAIL reset_rsp_x: got %h want 0", rsp_x); end
    n_vec++; if (rsp_y !== '0) begin n_err++; $display("FAIL reset_rsp_y: got %h want 0", rsp_y); end
    n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_vec++; if (core_d !== '0) begin n_err++; $display("FAIL reset_core_d: got %h want 0", core_d); end
  endtask

  task automatic test_contention();
    s0 = n_start;
    tick();
    rst_n = 1'b1;
    wait_ack(40, a, at);
    n_vec++; if (a !== 2'b01) begin n_err++; $display("FAIL cont_first: got %b want 01", a); end
    n_vec++; if (rsp_x !== 163'hA) begin n_err++; $display("FAIL cont_first_x: got %h want a", rsp_x); end
    tick(); req = 2'b10;
    tick(); tick(); req = 2'b11; req_d[0 +: M] = 163'h3;
    wait_ack(40, a, at);
    n_vec++; if (a !== 2'b10) begin n_err++; $display("FAIL cont_second: got %b want 10", a); end
    n_vec++; if (rsp_x !== 163'h12) begin n_err++; $display("FAIL cont_second_x: got %h want 12", rsp_x); end
    tick(); req = 2'b01;
    tick(); tick(); req = 2'b11; req_d[M +: M] = 163'h21;
    wait_ack(40, a, at);
    n_vec++; if (a !== 2'b01) begin n_err++; $display("FAIL cont_third: got %b want 01", a); end
    n_vec++; if (rsp_x !== 163'h6) begin n_err++; $display("FAIL cont_third_x: got %h want 6", rsp_x); end
    tick(); req = 2'b10;
    wait_ack(40, a, at);
    n_vec++; if (a !== 2'b10) begin n_err++; $display("FAIL cont_fourth: got %b want 10", a); end
    n_vec++; if (rsp_x !== 163'h42) begin n_err++; $display("FAIL cont_fourth_x: got %h want 42", rsp_x); end
    tick(); req = 2'b00;
    @(negedge clk);
    n_vec++; if (n_start - s0 !== 4) begin n_err++; $display("FAIL cont_starts: got %0d want 4", n_start - s0); end
  endtask

  task automatic test_single();
    tick();
    req_d[0 +: M] = 163'h1;
    req = 2'b01;
    s0 = n_start;
    t0 = cyc;
    @(negedge clk);
    n_vec++; if (core_start !== 1'b0) begin n_err++; $display("FAIL single_start_early: got %b want 0", core_start); end
    @(negedge clk);
    n_vec++; if (core_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b want 1", core_start); end
    n_vec++; if (core_d !== 163'h1) begin n_err++; $display("FAIL single_core_d: got %h want 1", core_d); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge clk);
    n_vec++; if (core_start !== 1'b0) begin n_err++; $display("FAIL single_start_width: got %b want 0", core_start); end
    wait_ack(40, a, at);
    n_vec++; if (a !== 2'b01) begin n_err++; $display("FAIL single_ack: got %b want 01", a); end
    n_vec++; if (rsp_x !== GX) begin n_err++; $display("FAIL single_x: got %h want %h", rsp_x, GX); end
    n_vec++; if (rsp_y !== GY) begin n_err++; $display("FAIL single_y: got %h want %h", rsp_y, GY); end
    n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b want 0", rsp_err); end
    n_vec++; if (at - done_cyc !== 2) begin n_err++; $display("FAIL single_done_to_ack: got %0d want 2", at - done_cyc); end
    n_vec++; if (at - t0 !== 6) begin n_err++; $display("FAIL single_req_to_ack: got %0d want 6", at - t0); end
    tick(); req = 2'b00;
    repeat (3) @(negedge clk);
    n_vec++; if (n_start - s0 !== 1) begin n_err++; $display("FAIL single_starts: got %0d want 1", n_start - s0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    tick();
    req_d[M +: M] = 163'h40;
    req = 2'b10;
    tick(); tick();
    req = 2'b11; req_d[0 +: M] = 163'h7;
    wait_ack(40, a, at);
    n_vec++; if (a !== 2'b10) begin n_err++; $display("FAIL b2b_first: got %b want 10", a); end
    n_vec++; if (rsp_x !== 163'h80) begin n_err++; $display("FAIL b2b_first_x: got %h want 80", rsp_x); end
    tick(); req_d[M +: M] = 163'h11;
    wait_ack(40, a, at);
    n_vec++; if (a !== 2'b01) begin n_err++; $display("FAIL b2b_second: got %b want 01", a); end
    n_vec++; if (rsp_x !== 163'hE) begin n_err++; $display("FAIL b2b_second_x: got %h want e", rsp_x); end
    tick(); req = 2'b10;
    wait_ack(40, a, at);
    n_vec++; if (a !== 2'b10) begin n_err++; $display("FAIL b2b_third: got %b want 10", a); end
    n_vec++; if (rsp_x !== 163'h22) begin n_err++; $display("FAIL b2b_third_x: got %h want 22", rsp_x); end
    tick(); req = 2'b00;
  endtask

  task automatic test_clr();
    tick();
    req_d[0 +: M] = 163'h5;
    req = 2'b01;
    c0 = n_clr;
    tick(); tick(); tick();
    clr = 1'b1;
    @(negedge clk);
    n_vec++; if (core_clr !== 1'b1) begin n_err++; $display("FAIL clr_core_clr: got %b want 1", core_clr); end
    n_vec++; if (ack !== 2'b00) begin n_err++; $display("FAIL clr_ack: got %b want 00", ack); end
    tick();
    clr = 1'b0;
    req = 2'b00;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_busy: got %b want 0", busy); end
    n_vec++; if (core_clr !== 1'b0) begin n_err++; $display("FAIL clr_core_clr_low: got %b want 0", core_clr); end
    n_vec++; if (rsp_x !== 163'h22) begin n_err++; $display("FAIL clr_rsp_kept: got %h want 22", rsp_x); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack !== 2'b00) seen = seen + 1;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL clr_no_ack: got %0d acks want 0", seen); end
    n_vec++; if (n_clr - c0 !== 1) begin n_err++; $display("FAIL clr_pulses: got %0d want 1", n_clr - c0); end
    tick();
    req_d[M +: M] = 163'h7;
    req = 2'b10;
    wait_ack(40, a, at);
    n_vec++; if (a !== 2'b10) begin n_err++; $display("FAIL clr_after_ack: got %b want 10", a); end
    n_vec++; if (rsp_x !== 163'hE) begin n_err++; $display("FAIL clr_after_x: got %h want e", rsp_x); end
    tick(); req = 2'b00;
  endtask

  task automatic test_async_reset();
    tick();
    req_d[0 +: M] = 163'h3;
    req = 2'b01;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_vec++; if (ack !== 2'b00) begin n_err++; $display("FAIL arst_ack: got %b want 00", ack); end
    n_vec++; if (rsp_x !== '0) begin n_err++; $display("FAIL arst_rsp_x: got %h want 0", rsp_x); end
    n_vec++; if (core_d !== '0) begin n_err++; $display("FAIL arst_core_d: got %h want 0", core_d); end
    n_vec++; if (core_start !== 1'b0) begin n_err++; $display("FAIL arst_core_start: got %b want 0", core_start); end
    tick(); tick();
    rst_n = 1'b1;
    t0 = cyc;
    wait_ack(40, a, at);
    n_vec++; if (a !== 2'b01) begin n_err++; $display("FAIL arst_ack_after: got %b want 01", a); end
    n_vec++; if (rsp_x !== 163'h6) begin n_err++; $display("FAIL arst_x: got %h want 6", rsp_x); end
    n_vec++; if (at - t0 !== 6) begin n_err++; $display("FAIL arst_latency: got %0d want 6", at - t0); end
    tick(); req = 2'b00;
  endtask

`ifdef SECT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    tick();
    hang = 1'b1;
    c0 = n_clr;
    req_d[0 +: M] = 163'h9;
    req = 2'b01;
    t0 = cyc;
    wait_ack(60, a, at);
    n_vec++; if (a !== 2'b01) begin n_err++; $display("FAIL tmo_ack: got %b want 01", a); end
    n_vec++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b want 1", rsp_err); end
    n_vec++; if (rsp_x !== '0) begin n_err++; $display("FAIL tmo_x: got %h want 0", rsp_x); end
    n_vec++; if (at - t0 !== 19) begin n_err++; $display("FAIL tmo_latency: got %0d want 19", at - t0); end
    tick(); req = 2'b00; hang = 1'b0;
    @(negedge clk);
    n_vec++; if (n_clr - c0 !== 1) begin n_err++; $display("FAIL tmo_clr_pulses: got %0d want 1", n_clr - c0); end
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_back_to_back();
    test_clr();
    test_async_reset();
`ifdef SECT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "time limit");
  end

endmodule
